// File: rtl/ring_target_agent.sv
// ring_target_agent: ring stop that services local reads/writes from a word array and injects RD_RSP responses.
module ring_target_agent #(
   parameter int DEPTH          = 256,
   parameter int RSP_FIFO_DEPTH = 4
) (
   input  logic                              QClk,
   input  logic                              RstQnnnH,
   input  logic [7:0]                        CoreID,
   input  logic                              RingReqInValidQ500H,
   input  logic [9:0]                        RingReqInRequestorQ500H,
   input  logic [1:0]                        RingReqInOpcodeQ500H,
   input  logic [31:0]                       RingReqInAddressQ500H,
   input  logic [31:0]                       RingReqInDataQ500H,
   input  logic                              RingRspInValidQ500H,
   input  logic [9:0]                        RingRspInRequestorQ500H,
   input  logic [1:0]                        RingRspInOpcodeQ500H,
   input  logic [31:0]                       RingRspInAddressQ500H,
   input  logic [31:0]                       RingRspInDataQ500H,
   output logic                              RingReqOutValidQ502H,
   output logic [9:0]                        RingReqOutRequestorQ502H,
   output logic [1:0]                        RingReqOutOpcodeQ502H,
   output logic [31:0]                       RingReqOutAddressQ502H,
   output logic [31:0]                       RingReqOutDataQ502H,
   output logic                              RingRspOutValidQ502H,
   output logic [9:0]                        RingRspOutRequestorQ502H,
   output logic [1:0]                        RingRspOutOpcodeQ502H,
   output logic [31:0]                       RingRspOutAddressQ502H,
   output logic [31:0]                       RingRspOutDataQ502H,
   output logic [$clog2(RSP_FIFO_DEPTH):0]   RspFifoCount
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = $clog2(RSP_FIFO_DEPTH);
   localparam int CW = PW + 1;
   typedef enum logic [1:0] {RD = 2'b00, RD_RSP = 2'b01, WR = 2'b10, WR_BCAST = 2'b11} t_opcode;
   typedef struct packed {
      logic        v;
      logic [9:0]  rq;
      logic [1:0]  op;
      logic [31:0] ad;
      logic [31:0] d;
   } t_slot;
   t_slot req_in, rsp_in, req_q, rsp_q, req_n, rsp_n, req_o, rsp_o, new_rsp;
   t_slot fifo [RSP_FIFO_DEPTH];
   logic [31:0] mem [DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   logic [AW-1:0] idx;
   logic lcl, wr, push, pop, full, empty;
   assign req_in = {RingReqInValidQ500H, RingReqInRequestorQ500H, RingReqInOpcodeQ500H,
                    RingReqInAddressQ500H, RingReqInDataQ500H};
   assign rsp_in = {RingRspInValidQ500H, RingRspInRequestorQ500H, RingRspInOpcodeQ500H,
                    RingRspInAddressQ500H, RingRspInDataQ500H};
   always_comb begin
      idx     = req_q.ad[AW+1:2];
      lcl     = req_q.v && req_q.ad[31:24] == CoreID;
      wr      = lcl && (req_q.op == WR || req_q.op == WR_BCAST);
      full    = count == CW'(RSP_FIFO_DEPTH);
      empty   = count == '0;
      // full is sampled before this cycle's pop, so a full FIFO never accepts
      push    = lcl && req_q.op == RD && !full;
      pop     = !rsp_q.v && !empty;
      new_rsp = '{v: 1'b1, rq: req_q.rq, op: RD_RSP, ad: req_q.ad, d: mem[idx]};
      req_n   = req_q;
      req_n.v = req_q.v && !(push || (lcl && req_q.op == WR));
      rsp_n   = pop ? fifo[rd_ptr] : rsp_q;
   end
   always_ff @(posedge QClk) begin
      if (RstQnnnH) begin
         req_q  <= '0;
         rsp_q  <= '0;
         req_o  <= '0;
         rsp_o  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         req_q  <= req_in;
         rsp_q  <= rsp_in;
         req_o  <= req_n;
         rsp_o  <= rsp_n;
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop) rd_ptr <= rd_ptr + PW'(1);
         count  <= count + CW'(push) - CW'(pop);
      end
   end
   // storage is intentionally not reset; writes are gated by reset-cleared valids
   always_ff @(posedge QClk) begin
      if (wr) mem[idx] <= req_q.d;
      if (push) fifo[wr_ptr] <= new_rsp;
   end
   assign {RingReqOutValidQ502H, RingReqOutRequestorQ502H, RingReqOutOpcodeQ502H,
           RingReqOutAddressQ502H, RingReqOutDataQ502H} = req_o;
   assign {RingRspOutValidQ502H, RingRspOutRequestorQ502H, RingRspOutOpcodeQ502H,
           RingRspOutAddressQ502H, RingRspOutDataQ502H} = rsp_o;
   assign RspFifoCount = count;
endmodule

// File: tb/tb_ring_target_agent.sv
// tb_ring_target_agent: directed checks of forwarding, local service, backpressure and FIFO drain.
module tb_ring_target_agent;
   logic        QClk = 1'b0;
   logic        RstQnnnH;
   logic [7:0]  CoreID;
   logic        req_v, rsp_v;
   logic [9:0]  req_rq, rsp_rq;
   logic [1:0]  req_op, rsp_op;
   logic [31:0] req_ad, req_d, rsp_ad, rsp_d;
   logic        ro_v, so_v;
   logic [9:0]  ro_rq, so_rq;
   logic [1:0]  ro_op, so_op;
   logic [31:0] ro_ad, ro_d, so_ad, so_d;
   logic [2:0]  cnt;
   int n_cmp = 0;
   int n_err = 0;
   ring_target_agent #(.DEPTH(256), .RSP_FIFO_DEPTH(4)) dut (
      .QClk(QClk), .RstQnnnH(RstQnnnH), .CoreID(CoreID),
      .RingReqInValidQ500H(req_v), .RingReqInRequestorQ500H(req_rq), .RingReqInOpcodeQ500H(req_op),
      .RingReqInAddressQ500H(req_ad), .RingReqInDataQ500H(req_d),
      .RingRspInValidQ500H(rsp_v), .RingRspInRequestorQ500H(rsp_rq), .RingRspInOpcodeQ500H(rsp_op),
      .RingRspInAddressQ500H(rsp_ad), .RingRspInDataQ500H(rsp_d),
      .RingReqOutValidQ502H(ro_v), .RingReqOutRequestorQ502H(ro_rq), .RingReqOutOpcodeQ502H(ro_op),
      .RingReqOutAddressQ502H(ro_ad), .RingReqOutDataQ502H(ro_d),
      .RingRspOutValidQ502H(so_v), .RingRspOutRequestorQ502H(so_rq), .RingRspOutOpcodeQ502H(so_op),
      .RingRspOutAddressQ502H(so_ad), .RingRspOutDataQ502H(so_d),
      .RspFifoCount(cnt)
   );
   always #5 QClk = ~QClk;
   task automatic tick();
      @(posedge QClk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic req(input logic v, input logic [9:0] rq, input logic [1:0] op, input logic [31:0] ad, input logic [31:0] d);
      req_v = v; req_rq = rq; req_op = op; req_ad = ad; req_d = d;
   endtask
   task automatic rsp(input logic v);
      rsp_v = v; rsp_rq = v ? 10'h3FF : '0; rsp_op = v ? 2'b01 : '0;
      rsp_ad = v ? 32'h1234_0000 : '0; rsp_d = v ? 32'h0000_CAFE : '0;
   endtask
   initial begin
      CoreID = 8'd3;
      RstQnnnH = 1'b1;
      req(1'b1, 10'h001, 2'b00, 32'h0400_0000, 32'h0);
      rsp(1'b1);
      tick(); tick();
      chk("rst_req_v", 64'(ro_v), 64'd0);
      chk("rst_rsp_v", 64'(so_v), 64'd0);
      chk("rst_cnt", 64'(cnt), 64'd0);
      chk("rst_req_ad", 64'(ro_ad), 64'd0);
      RstQnnnH = 1'b0;
      tick();
      chk("post_rst_1cyc_v", 64'(ro_v), 64'd0);
      tick();
      chk("post_rst_2cyc_v", 64'(ro_v), 64'd1);
      chk("post_rst_2cyc_ad", 64'(ro_ad), 64'h0400_0000);
      chk("post_rst_rsp_v", 64'(so_v), 64'd1);
      req(1'b0, '0, '0, '0, '0);
      rsp(1'b0);
      tick(); tick();
      // forward a non-local read
      req(1'b1, 10'h011, 2'b00, 32'h0400_0010, 32'h0);
      tick();
      req(1'b0, '0, '0, '0, '0);
      tick();
      chk("fwd_v", 64'(ro_v), 64'd1);
      chk("fwd_slot", {12'h0, ro_rq, ro_op, ro_ad, 8'h0}, {12'h0, 10'h011, 2'b00, 32'h0400_0010, 8'h0});
      chk("fwd_d", 64'(ro_d), 64'd0);
      chk("fwd_rsp_idle", 64'(so_v), 64'd0);
      // write then read same word
      req(1'b1, 10'h005, 2'b10, 32'h0300_0008, 32'hDEAD_BEEF);
      tick();
      req(1'b1, 10'h012, 2'b00, 32'h0300_0008, 32'h0);
      tick();
      chk("wr_consumed", 64'(ro_v), 64'd0);
      req(1'b0, '0, '0, '0, '0);
      tick();
      chk("rd_consumed", 64'(ro_v), 64'd0);
      chk("rd_push_cnt", 64'(cnt), 64'd1);
      tick();
      chk("rd_rsp_v", 64'(so_v), 64'd1);
      chk("rd_rsp_hdr", {22'h0, so_rq, so_op, so_ad}, {22'h0, 10'h012, 2'b01, 32'h0300_0008});
      chk("rd_rsp_d", 64'(so_d), 64'hDEAD_BEEF);
      chk("rd_pop_cnt", 64'(cnt), 64'd0);
      // broadcast write: forwarded and written locally
      req(1'b1, 10'h007, 2'b11, 32'h0300_0004, 32'h5);
      tick();
      req(1'b0, '0, '0, '0, '0);
      tick();
      chk("bcast_v", 64'(ro_v), 64'd1);
      chk("bcast_slot", {ro_op, ro_ad, ro_d[29:0]}, {2'b11, 32'h0300_0004, 30'h5});
      req(1'b1, 10'h013, 2'b00, 32'h0300_0004, 32'h0);
      tick();
      req(1'b0, '0, '0, '0, '0);
      tick(); tick();
      chk("bcast_rd_d", 64'(so_d), 64'h5);
      chk("bcast_rd_rq", 64'(so_rq), 64'h013);
      // preload words for backpressure test
      for (int k = 0; k < 5; k++) begin
         req(1'b1, 10'h0, 2'b10, 32'h0300_0020 + 32'(4 * k), 32'h100 + 32'(k));
         tick();
      end
      req(1'b0, '0, '0, '0, '0);
      rsp(1'b1);
      tick();
      for (int k = 0; k < 5; k++) begin
         req(1'b1, 10'h020 + 10'(k), 2'b00, 32'h0300_0020 + 32'(4 * k), 32'h0);
         tick();
      end
      req(1'b0, '0, '0, '0, '0);
      tick();
      chk("bp_cnt_full", 64'(cnt), 64'd4);
      chk("bp_5th_fwd_v", 64'(ro_v), 64'd1);
      chk("bp_5th_fwd", {22'h0, ro_rq, ro_ad}, {22'h0, 10'h024, 32'h0300_0030});
      chk("bp_rsp_pass", 64'(so_d), 64'hCAFE);
      rsp(1'b0);
      tick();
      chk("bp_last_pass", {so_rq, so_d}, {10'h3FF, 32'hCAFE});
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("drain_v", 64'(so_v), 64'd1);
         chk("drain_entry", {so_rq, so_d}, {10'h020 + 10'(k), 32'h100 + 32'(k)});
         chk("drain_cnt", 64'(cnt), 64'(3 - k));
      end
      tick();
      chk("drain_idle", 64'(so_v), 64'd0);
      // simultaneous push and pop at count 2
      rsp(1'b1);
      req(1'b1, 10'h030, 2'b00, 32'h0300_0020, 32'h0);
      tick();
      req(1'b1, 10'h031, 2'b00, 32'h0300_0024, 32'h0);
      tick();
      req(1'b1, 10'h032, 2'b00, 32'h0300_0028, 32'h0);
      rsp(1'b0);
      tick();
      chk("sim_cnt_before", 64'(cnt), 64'd2);
      req(1'b0, '0, '0, '0, '0);
      tick();
      chk("sim_cnt_same", 64'(cnt), 64'd2);
      chk("sim_oldest", {so_v, so_rq, so_d}, {1'b1, 10'h030, 32'h100});
      tick();
      chk("sim_next", {so_rq, so_d, 1'b0, cnt}, {10'h031, 32'h101, 1'b0, 3'd1});
      tick();
      chk("sim_last", {so_rq, so_d, 1'b0, cnt}, {10'h032, 32'h102, 1'b0, 3'd0});
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/ring_target_agent.md
Name: ring_target_agent

Overview:
- Ring endpoint for a memory-mapped target (responder) on the LOTR request/response ring.
- Consumes requests addressed to its tile, services them from a local word array, and injects RD_RSP responses into free response-ring slots.
- All non-matching traffic is forwarded with the standard two-stage Q500H->Q502H latency.
- Instantiated as a ring stop between tiles, like any other tile ring controller.

Parameters:
- DEPTH, 256, number of 32-bit words in the local array (power of 2).
- RSP_FIFO_DEPTH, 4, pending-response FIFO entries (power of 2, >=2).

Ports:
- QClk  in  1  clock.
- RstQnnnH  in  1  synchronous active-high reset.
- CoreID  in  8  tile ID; a request is local when Address[31:24]==CoreID.
- RingReqInValidQ500H / RequestorQ500H / OpcodeQ500H / AddressQ500H / DataQ500H  in  1/10/2/32/32  request ring input slot.
- RingRspInValidQ500H / RequestorQ500H / OpcodeQ500H / AddressQ500H / DataQ500H  in  1/10/2/32/32  response ring input slot.
- RingReqOutValidQ502H ... DataQ502H  out  1/10/2/32/32  request ring output slot.
- RingRspOutValidQ502H ... DataQ502H  out  1/10/2/32/32  response ring output slot.
- RspFifoCount  out  $clog2(RSP_FIFO_DEPTH)+1  debug occupancy.

Behaviour:
- Opcode encoding (t_opcode): RD=2'b00, RD_RSP=2'b01, WR=2'b10, WR_BCAST=2'b11.
- Reset: all Out valids 0; all Out payloads 0; FIFO empty; RspFifoCount 0. Array contents are not reset. Reset mid-operation drops all in-flight slots and pending responses.
- Pipeline:
  - Q500H inputs are registered into Q501H.
  - Decisions are made in Q501H.
  - Q502H outputs are registered. Fixed 2-cycle latency on both rings.
- Word index = Address[$clog2(DEPTH)+1:2]. Address[1:0] is ignored.
- Request decode at Q501H (local = valid && Address[31:24]==CoreID):
  - Not local, any opcode: forward unchanged.
  - Local WR: write Data to the array at the Q501H edge. Slot is consumed (ReqOut valid 0). No response (posted write).
  - Local WR_BCAST: write locally. Also forward unchanged, so other tiles see it.
  - Local RD with FIFO not full: read the array combinationally and push {Requestor, RD_RSP, Address, rdata}. Slot is consumed.
  - Local RD with FIFO full: forward unchanged. The request circulates and retries on its next lap. No loss, no stall.
  - Local RD_RSP on the request ring is illegal: forward unchanged.
  - Write-then-read to the same word in consecutive cycles returns the new data. No bypass is needed, because the write lands before the next Q501H read.
- Response path at Q501H:
  - Incoming rsp valid: forward unchanged.
  - Incoming rsp slot empty and FIFO not empty: pop the head into RingRspOut at Q502H.
  - Never overwrite a valid incoming response.
- FIFO rules:
  - Push and pop in the same cycle: count unchanged, data order preserved.
  - The push decision uses the full flag before this cycle's pop. A full FIFO rejects the push even if it pops that cycle.
  - Pointers wrap modulo RSP_FIFO_DEPTH. Strict FIFO order.
  - Pop only when not empty; push only when not full.
- The req and rsp rings are independent. A consumed request frees its slot; the freed slot is not refilled by this block.

Test Plan:
- Reset: assert RstQnnnH 2 cycles with ring traffic present -> all Out valids 0, RspFifoCount 0; first forwarded slot appears exactly 2 cycles after reset release.
- Forward: CoreID=3, req RD Address=32'h0400_0010 Requestor=10'h011 -> identical slot on ReqOut 2 cycles later; RspOut idle.
- Write then read: WR Addr=32'h0300_0008 Data=32'hDEAD_BEEF, next cycle RD same address, Requestor=10'h012 -> ReqOut valid 0 both cycles; RspOut RD_RSP Requestor=10'h012 Data=32'hDEAD_BEEF.
- Broadcast: WR_BCAST Addr=32'h0300_0004 Data=32'h5 -> forwarded unchanged on ReqOut, and a later local RD of that word returns 32'h5.
- Backpressure:
  - Hold RspIn valid continuously; issue 5 local RDs with RSP_FIFO_DEPTH=4 -> RspFifoCount reaches 4 and the 5th RD is forwarded on ReqOut.
  - Drop RspIn valid -> 4 responses drain in push order, one per cycle.
- Simultaneous: FIFO count=2, local RD arrives while RspIn is empty -> push and pop in the same cycle, count stays 2, popped entry is the oldest.
